pack_s3_ctrl: RTL

- Sequencing controller for the 5-trit→8-bit packing datapath in the Encaps pack-S3 path.
- Accepts a polynomial as a stream of trits and groups them 5 at a time.
- Drives an external trit5-to-bit8 converter through its load / count / accumulate sequence.
- Emits the packed bytes on a valid/ready stream. Last partial group is zero-padded.

---
 rtl/pack_s3_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pack_s3_ctrl.sv
// pack_s3_ctrl: groups a trit stream five at a time, sequences the trit5-to-bit8 converter and streams the packed bytes
module pack_s3_ctrl #(
  parameter int N_TRIT = 701,
  parameter int N_BYTE = 141
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  input  logic       trit_valid_i,
  output logic       trit_ready_o,
  input  logic [1:0] trit_data_i,
  output logic       byte_valid_o,
  input  logic       byte_ready_i,
  output logic [7:0] byte_data_o,
  output logic       conv_ld_o,
  output logic [9:0] conv_a_o,
  output logic [1:0] conv_count_o,
  input  logic [7:0] conv_out_i
);
  localparam int TW = $clog2(N_TRIT + 1);
  localparam int BW = $clog2(N_BYTE);
  localparam logic [TW-1:0] T_LAST = TW'(N_TRIT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(N_BYTE - 1);
  typedef enum logic [2:0] {IDLE, FILL, LOAD, ACC, CAPT, EMIT, DONE} state_t;
  state_t        state_q;
  logic [TW-1:0] tcnt_q;
  logic [BW-1:0] bcnt_q;
  logic [2:0]    k_q;
  logic [9:0]    grp_q, grp_d, conv_a_q;
  logic [7:0]    byte_q;
  logic [1:0]    cnt_q;
  logic          busy_q, done_q, err_q, trdy_q, bval_q, ld_q;
  always_comb begin
    grp_d = grp_q;
    grp_d[{k_q, 1'b0} +: 2] = (trit_data_i == 2'b11) ? 2'b00 : trit_data_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tcnt_q   <= '0;
      bcnt_q   <= '0;
      k_q      <= '0;
      grp_q    <= '0;
      conv_a_q <= '0;
      byte_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      trdy_q   <= 1'b0;
      bval_q   <= 1'b0;
      ld_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          state_q <= FILL;
          busy_q  <= 1'b1;
          trdy_q  <= 1'b1;
          tcnt_q  <= '0;
          bcnt_q  <= '0;
          k_q     <= '0;
          grp_q   <= '0;
          err_q   <= 1'b0;
        end
        FILL: if (trit_valid_i) begin
          grp_q  <= grp_d;
          k_q    <= k_q + 3'd1;
          tcnt_q <= tcnt_q + 1'b1;
          if (trit_data_i == 2'b11) err_q <= 1'b1;
          if (k_q == 3'd4 || tcnt_q == T_LAST) begin
            state_q  <= LOAD;
            trdy_q   <= 1'b0;
            ld_q     <= 1'b1;
            conv_a_q <= grp_d;
          end
        end
        LOAD: begin
          state_q <= ACC;
          ld_q    <= 1'b0;
          cnt_q   <= 2'd0;
        end
        ACC: begin
          cnt_q   <= cnt_q + 2'd1;
          state_q <= (cnt_q == 2'd3) ? CAPT : ACC;
        end
        CAPT: begin
          byte_q  <= conv_out_i;
          bval_q  <= 1'b1;
          state_q <= EMIT;
        end
        EMIT: if (byte_ready_i) begin
          bval_q <= 1'b0;
          if (bcnt_q == B_LAST) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= FILL;
            bcnt_q  <= bcnt_q + 1'b1;
            grp_q   <= '0;
            k_q     <= '0;
            trdy_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign trit_ready_o = trdy_q;
  assign byte_valid_o = bval_q;
  assign byte_data_o  = byte_q;
  assign conv_ld_o    = ld_q;
  assign conv_a_o     = conv_a_q;
  assign conv_count_o = cnt_q;
endmodule
